// File: rtl/grf_writeback_regfile_if.sv
// Pipeline-side bus of the general-purpose register file: D-stage reads,
// W-stage commit and debug observation of committed writes.
interface grf_writeback_regfile_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned CountWidth = 32;

  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;
  logic                  RegWrite_W;
  logic [ADDR_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0] Result_W;
  logic [DATA_WIDTH-1:0] PC_W;
  logic [DATA_WIDTH-1:0] LastWrPC;
  logic [CountWidth-1:0] WrCount;

  // Pipeline (decode/writeback) side
  modport master (
    output A1, A2, RegWrite_W, A3, Result_W, PC_W,
    input  RD1, RD2, LastWrPC, WrCount
  );

  // Register file side
  modport slave (
    input  A1, A2, RegWrite_W, A3, Result_W, PC_W,
    output RD1, RD2, LastWrPC, WrCount
  );
endinterface

// File: rtl/grf_writeback_regfile.sv
// Architectural register file: commits the W-stage result, serves two
// combinational D-stage reads with optional same-cycle write bypass.
module grf_writeback_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  grf_writeback_regfile_if.slave   bus
);

  localparam int unsigned NumRegs    = 2 ** ADDR_WIDTH;
  localparam int unsigned CountWidth = 32;

  logic [DATA_WIDTH-1:0] regBank [NumRegs];
  logic [DATA_WIDTH-1:0] lastWrPc;
  logic [CountWidth-1:0] wrCount;
  logic                  doCommit;

  // Register 0 is never a commit target, so its entry stays at the reset value
  assign doCommit = bus.RegWrite_W && (bus.A3 != '0);

  // Commit path: register write plus debug capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regBank[i] <= '0;
      end
      lastWrPc <= '0;
      wrCount  <= '0;
    end else if (doCommit) begin
      regBank[bus.A3] <= bus.Result_W;
      lastWrPc        <= bus.PC_W;
      wrCount         <= wrCount + CountWidth'(1);
    end
  end

  // Read port 1; reads are forced to zero while reset is held
  always_comb begin
    bus.RD1 = '0;
    if (reset_n && (bus.A1 != '0)) begin
      if (BYPASS_EN && doCommit && (bus.A3 == bus.A1)) begin
        bus.RD1 = bus.Result_W;
      end else begin
        bus.RD1 = regBank[bus.A1];
      end
    end
  end

  // Read port 2, same rules as port 1
  always_comb begin
    bus.RD2 = '0;
    if (reset_n && (bus.A2 != '0)) begin
      if (BYPASS_EN && doCommit && (bus.A3 == bus.A2)) begin
        bus.RD2 = bus.Result_W;
      end else begin
        bus.RD2 = regBank[bus.A2];
      end
    end
  end

  assign bus.LastWrPC = lastWrPc;
  assign bus.WrCount  = wrCount;

endmodule

// File: tb/tb_grf_writeback_regfile.sv
// Directed bench for grf_writeback_regfile: one bypassing and one
// non-bypassing instance driven in lockstep against a register-array model.
module tb_grf_writeback_regfile;

  logic        clk;
  logic        reset_n;
  logic [4:0]  a1, a2, a3;
  logic        we;
  logic [31:0] res, pc;

  int vectors     = 0;
  int miscompares = 0;

  grf_writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) busB ();
  grf_writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) busN ();

  assign busB.A1 = a1;  assign busB.A2 = a2;  assign busB.A3 = a3;
  assign busB.RegWrite_W = we;  assign busB.Result_W = res;  assign busB.PC_W = pc;
  assign busN.A1 = a1;  assign busN.A2 = a2;  assign busN.A3 = a3;
  assign busN.RegWrite_W = we;  assign busN.Result_W = res;  assign busN.PC_W = pc;

  grf_writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(busB)
  );
  grf_writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dutN (
    .clk(clk), .reset_n(reset_n), .bus(busN)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural state as plain arrays and counters
  logic [31:0] mRegs [32];
  logic [31:0] mLastPc;
  logic [31:0] mCount;
  logic [31:0] countOffset = 32'h0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
      mLastPc = 32'h0;
      mCount  = 32'h0;
    end else if (we === 1'b1 && a3 != 5'd0) begin
      mRegs[a3] = res;
      mLastPc   = pc;
      mCount    = mCount + 32'd1;
    end
  end

  function automatic logic [31:0] expRd(input logic [4:0] a, input bit byp);
    if (reset_n !== 1'b1 || a == 5'd0) return 32'h0;
    if (byp && we === 1'b1 && a3 != 5'd0 && a3 == a) return res;
    return mRegs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("B.RD1", busB.RD1, expRd(a1, 1'b1));
    check("B.RD2", busB.RD2, expRd(a2, 1'b1));
    check("N.RD1", busN.RD1, expRd(a1, 1'b0));
    check("N.RD2", busN.RD2, expRd(a2, 1'b0));
    check("B.LastWrPC", busB.LastWrPC, mLastPc);
    check("N.LastWrPC", busN.LastWrPC, mLastPc);
    check("B.WrCount", busB.WrCount, mCount + countOffset);
    check("N.WrCount", busN.WrCount, mCount + countOffset);
  end

  // Apply one cycle of inputs shortly after the rising edge
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] d,
                      input logic [31:0] p, input logic [4:0] ra1, input logic [4:0] ra2);
    @(posedge clk);
    #2;
    we = w; a3 = wa; res = d; pc = p; a1 = ra1; a2 = ra2;
    #1;
  endtask

  initial begin
    we = 1'b0; a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; res = 32'h0; pc = 32'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst.RD1", busB.RD1, 32'h0);
    check("rst.WrCount", busB.WrCount, 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Post-reset reads
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
    check("init.RD1", busB.RD1, 32'h0);
    check("init.RD2", busN.RD2, 32'h0);
    check("init.WrCount", busB.WrCount, 32'h0);
    check("init.LastWrPC", busB.LastWrPC, 32'h0);

    // First commit, then read back
    step(1'b1, 5'd8, 32'h1234_5678, 32'h3000, 5'd8, 5'd0);
    check("wr8.bypass", busB.RD1, 32'h1234_5678);
    check("wr8.nobypass", busN.RD1, 32'h0);
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0);
    check("rd8.RD1", busN.RD1, 32'h1234_5678);
    check("rd8.WrCount", busB.WrCount, 32'd1);
    check("rd8.LastWrPC", busB.LastWrPC, 32'h3000);

    // Write to register 0 is discarded and uncounted
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 5'd0, 5'd0);
    check("wr0.RD1", busB.RD1, 32'h0);
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd8);
    check("wr0.WrCount", busB.WrCount, 32'd1);
    check("wr0.LastWrPC", busB.LastWrPC, 32'h3000);

    // Same-cycle bypass on both ports
    step(1'b1, 5'd9, 32'h1, 32'h3008, 5'd0, 5'd0);
    step(1'b1, 5'd9, 32'hABCD, 32'h300C, 5'd9, 5'd9);
    check("byp.B.RD1", busB.RD1, 32'hABCD);
    check("byp.B.RD2", busB.RD2, 32'hABCD);
    check("byp.N.RD1", busN.RD1, 32'h1);
    check("byp.N.RD2", busN.RD2, 32'h1);
    step(1'b1, 5'd10, 32'h55, 32'h3010, 5'd8, 5'd9);
    check("diff.N.RD2", busN.RD2, 32'hABCD);
    check("diff.B.RD1", busB.RD1, 32'h1234_5678);
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd9);
    check("diff.WrCount", busB.WrCount, 32'd4);
    check("diff.RD1", busB.RD1, 32'h55);

    // Asynchronous reset between edges with a write pending
    step(1'b1, 5'd12, 32'h77, 32'h3014, 5'd8, 5'd9);
    reset_n = 1'b0;
    #1;
    check("arst.WrCount", busB.WrCount, 32'h0);
    check("arst.RD1", busB.RD1, 32'h0);
    check("arst.RD2", busN.RD2, 32'h0);
    check("arst.LastWrPC", busN.LastWrPC, 32'h0);
    @(negedge clk);
    we = 1'b0;
    #1 reset_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd8);
    check("arst.reg12", busB.RD1, 32'h0);
    check("arst.cnt", busN.WrCount, 32'h0);

    // Fill every register, reading neighbours as each commit happens
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 5'(i), (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000, 32'h4000 + 32'(i) * 32'd4,
           5'(i), 5'(i - 1));
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
    end
    check("fill.WrCount", busB.WrCount, 32'd31);
    check("fill.LastWrPC", busB.LastWrPC, 32'h407C);

    // Counter wrap
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4);
    force dutB.wrCount = 32'hFFFF_FFFF;
    force dutN.wrCount = 32'hFFFF_FFFF;
    countOffset = 32'hFFFF_FFFF - mCount;
    #1;
    release dutB.wrCount;
    release dutN.wrCount;
    check("wrap.pre", busB.WrCount, 32'hFFFF_FFFF);
    step(1'b1, 5'd3, 32'hDEAD_BEEF, 32'h5000, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
    check("wrap.B", busB.WrCount, 32'h0);
    check("wrap.N", busN.WrCount, 32'h0);
    check("wrap.reg3", busN.RD1, 32'hDEAD_BEEF);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grf_writeback_regfile.md
Name: grf_writeback_regfile

Overview:
General-purpose register file for the 5-stage MIPS pipeline. It is the consumer of the W-stage result bus: it commits Result_W into the architectural registers. It serves the two D-stage source-operand reads, with internal write-to-read bypass so that a same-cycle W-stage write is visible to the D-stage read. It also keeps a committed-write counter for debug and verification.

Parameters:
DATA_WIDTH, 32, register and result width
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)
BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the stored value only

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
A1  input  ADDR_WIDTH  D-stage read address, rs
A2  input  ADDR_WIDTH  D-stage read address, rt
RD1  output  DATA_WIDTH  read data for A1 (combinational)
RD2  output  DATA_WIDTH  read data for A2 (combinational)
RegWrite_W  input  1  W-stage write enable
A3  input  ADDR_WIDTH  W-stage destination register
Result_W  input  DATA_WIDTH  W-stage result (ALUOut / DMOut / PC+4, already selected upstream)
PC_W  input  DATA_WIDTH  W-stage instruction PC; captured for debug only
LastWrPC  output  DATA_WIDTH  PC_W of the most recent committed write
WrCount  output  32  number of committed register writes since reset

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed): all registers 0; LastWrPC=0; WrCount=0. Reads during reset return 0.
- Reset deassertion is synchronous to clk upstream; the first write can commit on the first rising edge with reset_n=1.
- Commit rule: on a rising edge with reset_n=1, RegWrite_W=1 and A3!=0:
  - reg[A3] <= Result_W
  - LastWrPC <= PC_W
  - WrCount <= WrCount+1, wrapping 0xFFFFFFFF -> 0
- If RegWrite_W=0 or A3=0: no register, LastWrPC or WrCount change.
- Register 0 is hardwired to 0. Writes to it are discarded and are not counted.
- Read, no bypass condition: RDn = (An==0) ? 0 : reg[An]. Purely combinational, zero-cycle latency.
- Bypass (BYPASS_EN=1): if RegWrite_W=1, A3!=0 and A3==An, then RDn = Result_W in the same cycle, before the edge.
  - Applies independently to RD1 and RD2; both may bypass at once when A1==A2==A3.
- BYPASS_EN=0: RDn shows the old value until after the edge; the hazard unit must then stall one cycle.
- Write and read of different registers in the same cycle: the read returns the stored value unaffected.
- Reset asserted mid-cycle while RegWrite_W=1: reset wins; no commit and counters stay 0.
- Reads stay combinational whatever the value of RegWrite_W.
- No X propagation: every register is defined from reset onward.

Test Plan:
- Reset with reset_n=0, then release; read A1=5, A2=31 -> RD1=RD2=0, WrCount=0, LastWrPC=0.
- Write RegWrite_W=1, A3=8, Result_W=0x12345678, PC_W=0x3000; next cycle A1=8 with RegWrite_W=0 -> RD1=0x12345678, WrCount=1, LastWrPC=0x3000.
- Write A3=0, Result_W=0xFFFFFFFF -> reg0 reads 0, WrCount unchanged.
- Same-cycle bypass: reg9=0x1, RegWrite_W=1, A3=9, Result_W=0xABCD, A1=A2=9 -> before the edge RD1=RD2=0xABCD. With BYPASS_EN=0 -> RD1=RD2=0x1 before the edge, 0xABCD after.
- Async reset pulse between edges after 3 writes -> WrCount and all registers 0 immediately, without a clock edge.
- Force WrCount to 0xFFFFFFFF, then commit one write -> WrCount=0.
